conv_2d: RTL and testbench

CONV_2D -- requirements
Module: conv_2d

---
 rtl/conv_2d.sv | 99 +++++++++
 tb/tb_conv_2d.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/conv_2d.sv
// conv_2d: single-output-channel 3x3 convolution, stride 1, zero padding p.
// All Ho*Wo outputs are computed combinationally from the current inputs.
// They are rounded toward negative infinity, saturated to N bits and
// registered once. There is no enable or handshake.
module conv_2d #(
    parameter int N = 16,
    parameter int Q = 8,
    parameter int h = 3,
    parameter int w = 4,
    parameter int c = 2,
    parameter int p = 1
) (
    input  logic                                       clk,
    input  logic                                       global_rst,
    input  logic signed [N*h*w*c-1:0]                  data,
    input  logic signed [9*N*c-1:0]                    filterWeight,
    input  logic signed [N-1:0]                        filterBias,
    output logic signed [N*(h-2+2*p)*(w-2+2*p)-1:0]    result
);

    localparam int HO    = h - 2 + 2*p;
    localparam int WO    = w - 2 + 2*p;
    // The accumulator holds 9*c full-width products exactly, with no overflow.
    localparam int ACC_W = 2*N + $clog2(9*c + 1);
    // Add one bit of headroom so that adding the bias cannot overflow either.
    localparam int SUM_W = ACC_W + 1;

    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-N+1){1'b1}}, {(N-1){1'b0}}};

    logic signed [N*HO*WO-1:0] result_next;
    logic signed [N-1:0]       x_val;
    logic signed [N-1:0]       w_val;
    logic signed [2*N-1:0]     prod;
    logic signed [ACC_W-1:0]   acc;
    logic signed [SUM_W-1:0]   bias_sh;
    logic signed [SUM_W-1:0]   sum;
    logic signed [SUM_W-1:0]   shifted;
    logic                      in_rng;
    int                        xr;
    int                        xc;
    int                        d_idx;

    // Compute every output pixel: multiply-accumulate, add bias, floor-shift, saturate.
    always_comb begin
        result_next = '0;
        x_val       = '0;
        w_val       = '0;
        prod        = '0;
        acc         = '0;
        sum         = '0;
        shifted     = '0;
        in_rng      = 1'b0;
        xr          = 0;
        xc          = 0;
        d_idx       = 0;
        bias_sh     = {{(SUM_W-N){filterBias[N-1]}}, filterBias} <<< Q;
        for (int r = 0; r < HO; r++) begin
            for (int col = 0; col < WO; col++) begin
                acc = '0;
                for (int ch = 0; ch < c; ch++) begin
                    for (int kr = 0; kr < 3; kr++) begin
                        for (int kc = 0; kc < 3; kc++) begin
                            xr     = r - p + kr;
                            xc     = col - p + kc;
                            in_rng = (xr >= 0) && (xr < h) && (xc >= 0) && (xc < w);
                            // Clamp the index so padded taps never form an out-of-range select.
                            d_idx  = in_rng ? ((ch*h + xr)*w + xc)*N : 0;
                            x_val  = in_rng ? data[d_idx +: N] : '0;
                            w_val  = filterWeight[(ch*9 + kr*3 + kc)*N +: N];
                            prod   = $signed({{N{x_val[N-1]}}, x_val}) *
                                     $signed({{N{w_val[N-1]}}, w_val});
                            acc    = acc + {{(ACC_W-2*N){prod[2*N-1]}}, prod};
                        end
                    end
                end
                sum     = {acc[ACC_W-1], acc} + bias_sh;
                shifted = sum >>> Q;
                if (shifted > SAT_MAX) begin
                    result_next[(r*WO + col)*N +: N] = SAT_MAX[N-1:0];
                end else if (shifted < SAT_MIN) begin
                    result_next[(r*WO + col)*N +: N] = SAT_MIN[N-1:0];
                end else begin
                    result_next[(r*WO + col)*N +: N] = shifted[N-1:0];
                end
            end
        end
    end

    // Output register: cleared asynchronously, loaded on every rising edge otherwise.
    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            result <= '0;
        end else begin
            result <= result_next;
        end
    end

endmodule

// File: tb/tb_conv_2d.sv
// Directed self-checking bench for conv_2d at its default parameters.
module tb_conv_2d;

    localparam int N  = 16;
    localparam int Q  = 8;
    localparam int H  = 3;
    localparam int W  = 4;
    localparam int C  = 2;
    localparam int P  = 1;
    localparam int HO = H - 2 + 2*P;
    localparam int WO = W - 2 + 2*P;

    logic                           clk = 1'b0;
    logic                           global_rst = 1'b0;
    logic signed [N*H*W*C-1:0]      data = '0;
    logic signed [9*N*C-1:0]        filterWeight = '0;
    logic signed [N-1:0]            filterBias = '0;
    logic signed [N*HO*WO-1:0]      result;

    int n_checks = 0;
    int n_fail   = 0;

    conv_2d #(.N(N), .Q(Q), .h(H), .w(W), .c(C), .p(P)) dut (
        .clk          (clk),
        .global_rst   (global_rst),
        .data         (data),
        .filterWeight (filterWeight),
        .filterBias   (filterBias),
        .result       (result)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [N-1:0] word(input int r, input int col);
        return result[(r*WO + col)*N +: N];
    endfunction

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [N-1:0] exp);
        for (int r = 0; r < HO; r++)
            for (int col = 0; col < WO; col++)
                check($sformatf("%s(%0d,%0d)", tag, r, col), word(r, col), exp);
    endtask

    task automatic set_x(input int ch, input int r, input int col, input logic [N-1:0] v);
        data[((ch*H + r)*W + col)*N +: N] = v;
    endtask

    task automatic set_w(input int ch, input int kr, input int kc, input logic [N-1:0] v);
        filterWeight[(ch*9 + kr*3 + kc)*N +: N] = v;
    endtask

    task automatic fill_x(input logic [N-1:0] v);
        for (int ch = 0; ch < C; ch++)
            for (int r = 0; r < H; r++)
                for (int col = 0; col < W; col++)
                    set_x(ch, r, col, v);
    endtask

    task automatic fill_w(input logic [N-1:0] v);
        for (int ch = 0; ch < C; ch++)
            for (int k = 0; k < 9; k++)
                set_w(ch, k / 3, k % 3, v);
    endtask

    task automatic load_example();
        int wrow [3][3];
        wrow = '{'{1, 0, 2}, '{3, 1, 0}, '{1, 2, 3}};
        for (int ch = 0; ch < C; ch++) begin
            for (int kr = 0; kr < 3; kr++)
                for (int kc = 0; kc < 3; kc++)
                    set_w(ch, kr, kc, 16'(wrow[kr][kc] * 256));
            for (int r = 0; r < H; r++)
                for (int col = 0; col < W; col++)
                    set_x(ch, r, col, (r == 0) ? 16'h0300 : ((ch == 0) ? 16'hFE00 : 16'h0200));
        end
        filterBias = 16'h0001;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Apply an asynchronous clear before the first clock edge.
        filterBias = 16'h0001;
        #2 global_rst = 1'b1;
        #1;
        check_all("rst_async", 16'h0000);
        // Clock edges that occur during reset are ignored.
        tick();
        tick();
        check("rst_hold(0,0)", word(0, 0), 16'h0000);
        check("rst_hold(2,3)", word(2, 3), 16'h0000);
        @(negedge clk);
        global_rst = 1'b0;
        tick();
        check_all("bias_only", 16'h0001);

        // Worked example; the result must not change before the next edge.
        @(negedge clk);
        load_example();
        #1;
        check("no_early_update", word(1, 1), 16'h0001);
        tick();
        check("ex(1,1)", word(1, 1), 16'h1201);
        check("ex(1,2)", word(1, 2), 16'h1201);
        check("ex(0,0)", word(0, 0), 16'h0601);
        check("ex(2,3)", word(2, 3), 16'h0001);

        // Pulse reset between edges, then restore on the following edge.
        @(negedge clk);
        #1 global_rst = 1'b1;
        #1;
        check("mid_rst_clear", word(1, 1), 16'h0000);
        #1 global_rst = 1'b0;
        #1;
        check("mid_rst_stays0", word(1, 1), 16'h0000);
        tick();
        check("mid_rst_restore", word(1, 1), 16'h1201);
        // Hold reset across an edge so that no in-flight value survives.
        @(negedge clk);
        global_rst = 1'b1;
        tick();
        check("rst_over_edge", word(0, 0), 16'h0000);
        @(negedge clk);
        global_rst = 1'b0;
        tick();
        check("rst_release(0,0)", word(0, 0), 16'h0601);

        // Positive saturation.
        @(negedge clk);
        fill_x(16'h7FFF);
        fill_w(16'h7FFF);
        filterBias = 16'h0000;
        tick();
        check("pos_sat(1,1)", word(1, 1), 16'h7FFF);
        check("pos_sat(1,2)", word(1, 2), 16'h7FFF);

        // Negative saturation.
        @(negedge clk);
        fill_w(16'h8000);
        tick();
        check("neg_sat(1,1)", word(1, 1), 16'h8000);
        check("neg_sat(1,2)", word(1, 2), 16'h8000);

        // Rounding toward negative infinity: -256/65536 becomes -1/256.
        @(negedge clk);
        fill_x(16'h0001);
        fill_w(16'h0000);
        set_w(0, 1, 1, 16'hFF00);
        tick();
        check_all("floor_m1", 16'hFFFF);
        // -128/65536 (that is, -0.5 LSB) also rounds down to -1 LSB.
        @(negedge clk);
        set_w(0, 1, 1, 16'hFF80);
        tick();
        check("floor_half_neg", word(1, 1), 16'hFFFF);
        // +0.5 LSB rounds down to 0.
        @(negedge clk);
        set_w(0, 1, 1, 16'h0080);
        tick();
        check("floor_half_pos", word(1, 1), 16'h0000);

        // Negative biases must be sign-extended.
        @(negedge clk);
        fill_x(16'h0000);
        filterBias = 16'hFFFF;
        tick();
        check("bias_m1(0,0)", word(0, 0), 16'hFFFF);
        check("bias_m1(2,3)", word(2, 3), 16'hFFFF);
        @(negedge clk);
        filterBias = 16'h8000;
        tick();
        check("bias_min(1,2)", word(1, 2), 16'h8000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
